// File: rtl/dvp_capture_ctrl.sv
// ============================================================================
// Module   : dvp_capture_ctrl
// Brief    : Frame capture sequencer between the DVP receiver and frame writer.
//            Arms on start, skips frames, forwards single or continuous frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dvp_capture_ctrl #(
    parameter int DATA_W = 24,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int SKIP_W = 4,
    parameter int FCNT_W = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    input  logic [SKIP_W-1:0] skip,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_len,
    output logic              err_ovf
);

    localparam int c_pixels = WIDTH * HEIGHT;
    localparam int c_pix_w  = $clog2(c_pixels + 1);
    localparam logic [c_pix_w-1:0] c_last_idx = c_pix_w'(c_pixels - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_SKIP    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_cont;
    logic [SKIP_W-1:0]   r_skip;
    logic [SKIP_W-1:0]   r_skip_left;
    logic [c_pix_w-1:0]  r_pix_cnt;
    logic                r_stop_pending;
    logic                r_out_valid;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_frame_done;
    logic [FCNT_W-1:0]   r_frame_cnt;
    logic                r_err_len;
    logic                r_err_ovf;

    logic w_load_ok;
    logic w_last;
    logic w_fwd;

    // The register may take a new beat when empty or when its beat leaves now.
    assign w_load_ok = !r_out_valid || out_ready;
    assign w_last    = (r_pix_cnt == c_last_idx);
    assign w_fwd     = in_valid &&
                       ((r_state == S_ARM && in_sop && r_skip_left == '0 && !stop) ||
                        (r_state == S_CAPTURE));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cont         <= 1'b0;
            r_skip         <= '0;
            r_skip_left    <= '0;
            r_pix_cnt      <= '0;
            r_stop_pending <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_sop      <= 1'b0;
            r_out_eop      <= 1'b0;
            r_out_data     <= '0;
            r_frame_done   <= 1'b0;
            r_frame_cnt    <= '0;
            r_err_len      <= 1'b0;
            r_err_ovf      <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            if (w_fwd) begin
                if (w_load_ok) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= in_data;
                    r_out_sop   <= (r_state == S_ARM);
                    r_out_eop   <= (r_state == S_CAPTURE) && w_last;
                end else begin
                    r_err_ovf <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_cont         <= continuous;
                        r_skip         <= skip;
                        r_skip_left    <= skip;
                        r_err_len      <= 1'b0;
                        r_err_ovf      <= 1'b0;
                        r_stop_pending <= 1'b0;
                        r_state        <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (in_valid && in_sop) begin
                        r_pix_cnt <= c_pix_w'(1);
                        if (r_skip_left != '0) begin
                            r_skip_left <= r_skip_left - SKIP_W'(1);
                            r_state     <= S_SKIP;
                        end else begin
                            r_state <= S_CAPTURE;
                        end
                    end
                end
                S_SKIP: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        r_pix_cnt <= r_pix_cnt + c_pix_w'(1);
                        if (w_last) begin
                            r_state <= S_ARM;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    // Frame length is set by the beat count, never by in_eop.
                    if (in_valid) begin
                        r_pix_cnt <= r_pix_cnt + c_pix_w'(1);
                        if (w_last) begin
                            if (!in_eop) begin
                                r_err_len <= 1'b1;
                            end
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + FCNT_W'(1);
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (r_cont && !r_stop_pending && !stop) begin
                        r_skip_left <= r_skip;
                        r_state     <= S_ARM;
                    end else begin
                        r_stop_pending <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_sop    = r_out_sop;
    assign out_eop    = r_out_eop;
    assign out_data   = r_out_data;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign err_len    = r_err_len;
    assign err_ovf    = r_err_ovf;

endmodule

`default_nettype wire

// File: tb/tb_dvp_capture_ctrl.sv
// ============================================================================
// Module   : tb_dvp_capture_ctrl
// Brief    : Scoreboard bench for dvp_capture_ctrl with a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dvp_capture_ctrl;

    localparam int DW   = 24;
    localparam int WID  = 4;
    localparam int HGT  = 2;
    localparam int SW   = 4;
    localparam int FW   = 16;
    localparam int NPIX = WID * HGT;

    logic          pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          continuous = 1'b0;
    logic [SW-1:0] skip = '0;
    logic          in_valid = 1'b0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          frame_done;
    logic [FW-1:0] frame_cnt;
    logic          err_len;
    logic          err_ovf;

    dvp_capture_ctrl #(
        .DATA_W(DW), .WIDTH(WID), .HEIGHT(HGT), .SKIP_W(SW), .FCNT_W(FW)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .start(start), .stop(stop),
        .continuous(continuous), .skip(skip),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop),
        .out_eop(out_eop), .out_data(out_data), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt),
        .err_len(err_len), .err_ovf(err_ovf)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad = 0;

    // Scoreboard of expected {sop, eop, data} beats, plus frame-level model.
    logic [DW+1:0] q[$];
    bit slot;
    bit ovf_exp, len_exp;
    int exp_cnt, exp_done, done_seen;
    bit active, m_cont;
    int m_skip, m_idx;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    initial begin
        logic [DW+1:0] e;
        forever begin
            @(negedge pclk);
            if (rst_n && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_beat: got unexpected beat %0d, expected none",
                             {out_sop, out_eop, out_data});
                end else begin
                    e = q.pop_front();
                    check("out_beat", {out_sop, out_eop, out_data}, e);
                end
            end
            if (rst_n && frame_done) done_seen++;
        end
    end

    function automatic bit rnd_rdy(input bit rnd);
        return rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    endfunction

    // One clock: the slot model applies the handshake rule for this cycle.
    task automatic step(input bit rdy, input bit fwd, input bit osop, input bit oeop);
        out_ready = rdy;
        if (fwd) begin
            if (!slot || rdy) begin
                q.push_back({osop, oeop, in_data});
                slot = 1'b1;
            end else begin
                ovf_exp = 1'b1;
            end
        end else if (slot && rdy) begin
            slot = 1'b0;
        end
        @(posedge pclk);
        #1;
        start = 1'b0; stop = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic do_start(input bit cont, input int sk, input bit with_stop);
        start = 1'b1; stop = with_stop; continuous = cont; skip = SW'(sk);
        if (!with_stop && !active) begin
            active = 1'b1; m_cont = cont; m_skip = sk; m_idx = 0;
            ovf_exp = 1'b0; len_exp = 1'b0;
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame(input bit bad_eop, input int stop_at, input int lo_a,
                         input int lo_b, input bit gaps, input bit rnd, input int rst_at);
        bit fwd;
        bit lo;
        fwd = active && (m_idx == m_skip);
        for (int b = 1; b <= NPIX; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step(rnd_rdy(rnd), 1'b0, 1'b0, 1'b0);
            in_valid = 1'b1; in_sop = (b <= 2); in_eop = (b == NPIX) && !bad_eop;
            in_data = DW'($urandom); stop = (b == stop_at);
            if (b == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_async_outputs",
                      {out_valid, out_sop, out_eop, out_data, busy, frame_done,
                       frame_cnt, err_len, err_ovf}, 0);
                q.delete(); slot = 1'b0; active = 1'b0; exp_cnt = 0;
                ovf_exp = 1'b0; len_exp = 1'b0;
                in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; stop = 1'b0;
                repeat (2) @(posedge pclk);
                #1 rst_n = 1'b1;
                return;
            end
            lo = (lo_a != 0) && (b >= lo_a) && (b <= lo_b);
            step(lo ? 1'b0 : rnd_rdy(rnd), fwd, b == 1, b == NPIX);
        end
        if (fwd) begin
            exp_cnt++; exp_done++; m_idx = 0;
            if (bad_eop) len_exp = 1'b1;
            if (!m_cont) active = 1'b0;
        end else if (active) begin
            m_idx++;
        end
        if (stop_at != 0) active = 1'b0;
        repeat (3) step(rnd_rdy(rnd), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_state(input string tag);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, "_queue_empty"}, q.size(), 0);
        check({tag, "_frame_cnt"}, frame_cnt, exp_cnt & 16'hFFFF);
        check({tag, "_done_pulses"}, done_seen, exp_done);
        check({tag, "_err_len"}, err_len, len_exp);
        check({tag, "_err_ovf"}, err_ovf, ovf_exp);
        check({tag, "_busy"}, busy, active);
    endtask

    initial begin
        slot = 0; ovf_exp = 0; len_exp = 0; exp_cnt = 0; exp_done = 0;
        done_seen = 0; active = 0; m_cont = 0; m_skip = 0; m_idx = 0;
        repeat (2) @(posedge pclk);
        #1;
        check("reset_outputs",
              {out_valid, out_sop, out_eop, out_data, busy, frame_done,
               frame_cnt, err_len, err_ovf}, 0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);

        // Single frame, no skip
        do_start(1'b0, 0, 1'b0);
        check("busy_after_start", busy, 1);
        frame(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        check_state("single");

        // Skip two frames, single capture
        do_start(1'b0, 2, 1'b0);
        repeat (3) frame(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        check_state("skip2");

        // Continuous, stop during second captured frame
        do_start(1'b1, 0, 1'b0);
        frame(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        frame(1'b0, 3, 0, 0, 1'b0, 1'b0, 0);
        frame(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        check_state("cont_stop");

        // Downstream stall drops beats 4 and 5
        do_start(1'b0, 0, 1'b0);
        frame(1'b0, 0, 4, 5, 1'b0, 1'b0, 0);
        check_state("stall");
        do_start(1'b0, 0, 1'b0);
        check("err_ovf_cleared", err_ovf, 0);
        frame(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        check_state("after_stall");

        // Missing in_eop on the last beat, then start+stop together
        do_start(1'b0, 0, 1'b0);
        frame(1'b1, 0, 0, 0, 1'b0, 1'b0, 0);
        check_state("bad_eop");
        do_start(1'b0, 1, 1'b1);
        check("start_stop_idle", busy, 0);

        // Asynchronous reset mid-capture, then a clean capture
        do_start(1'b0, 0, 1'b0);
        frame(1'b0, 0, 0, 0, 1'b0, 1'b0, 5);
        check_state("post_reset");
        do_start(1'b0, 0, 1'b0);
        frame(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        check_state("reset_recover");

        // Randomized sessions: mode, skip, gaps, ready, eop errors, stops
        for (int s = 0; s < 8; s++) begin
            int nf;
            do_start(1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
            nf = $urandom_range(2, 4);
            for (int f = 0; f < nf; f++) begin
                frame(1'($urandom_range(0, 4) == 0),
                      ((f == nf - 1) && ($urandom_range(0, 1) == 1)) ? $urandom_range(2, NPIX) : 0,
                      0, 0, 1'b1, 1'b1, 0);
            end
            check_state("random");
        end

        stop = 1'b1;
        active = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
